// File: rtl/mem_access_if.sv
// Bus bundle between execute, the memory stage and the data RAM.
// slave = memory stage view, master = execute/RAM side view.
interface mem_access_if;
  // request from execute
  logic        ex2mem_mem_en;
  logic        ex2mem_load;
  logic        ex2mem_store;
  logic        ex2mem_wr_mem;
  logic [31:0] ex2mem_memaddr;
  logic [31:0] ex2mem_wr_memwdata;
  logic [2:0]  ex2mem_mem_op;
  logic        ex2mem_wr_reg;
  logic [4:0]  ex2mem_wr_regindex;
  logic [31:0] ex2mem_wr_wdata;
  // data RAM
  logic [31:0] ram2mem_rdata;
  logic        mem2ram_we;
  logic [29:0] mem2ram_addr;
  logic [31:0] mem2ram_wdata;
  logic [3:0]  mem2ram_be;
  // feedback to execute
  logic        store_misaligned_exxeption;
  logic [31:0] mem2ex_memadr;
  logic [2:0]  mem2ex_mem_op;
  logic        ex2mem_store_ffout;
  logic        ex2mem_mem_en_ffout;
  logic        mem_stall;
  // writeback
  logic        mem2wb_wr_reg;
  logic [4:0]  mem2wb_wr_regindex;
  logic [31:0] mem2wb_wr_wdata;
  logic        load_misaligned_exp;
  logic [31:0] mem2wb_badaddr;

  modport slave (
    input  ex2mem_mem_en, ex2mem_load, ex2mem_store, ex2mem_wr_mem,
           ex2mem_memaddr, ex2mem_wr_memwdata, ex2mem_mem_op,
           ex2mem_wr_reg, ex2mem_wr_regindex, ex2mem_wr_wdata, ram2mem_rdata,
    output mem2ram_we, mem2ram_addr, mem2ram_wdata, mem2ram_be,
           store_misaligned_exxeption, mem2ex_memadr, mem2ex_mem_op,
           ex2mem_store_ffout, ex2mem_mem_en_ffout, mem_stall,
           mem2wb_wr_reg, mem2wb_wr_regindex, mem2wb_wr_wdata,
           load_misaligned_exp, mem2wb_badaddr
  );

  modport master (
    output ex2mem_mem_en, ex2mem_load, ex2mem_store, ex2mem_wr_mem,
           ex2mem_memaddr, ex2mem_wr_memwdata, ex2mem_mem_op,
           ex2mem_wr_reg, ex2mem_wr_regindex, ex2mem_wr_wdata, ram2mem_rdata,
    input  mem2ram_we, mem2ram_addr, mem2ram_wdata, mem2ram_be,
           store_misaligned_exxeption, mem2ex_memadr, mem2ex_mem_op,
           ex2mem_store_ffout, ex2mem_mem_en_ffout, mem_stall,
           mem2wb_wr_reg, mem2wb_wr_regindex, mem2wb_wr_wdata,
           load_misaligned_exp, mem2wb_badaddr
  );
endinterface

// File: rtl/mem_access.sv
// Memory access stage: one register stage on the execute request, RAM store
// with byte enables (word-crossing stores split over two cycles), load
// extract/extend and writeback mux.
module mem_access (
  input  logic          clk,
  input  logic          rstn,
  mem_access_if.slave   bus
);

  localparam logic [2:0] OP_B  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_W  = 3'd2;
  localparam logic [2:0] OP_BU = 3'd4;
  localparam logic [2:0] OP_HU = 3'd5;

  typedef struct packed {
    logic        mem_en;
    logic        load;
    logic        store;
    logic        wr_mem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  op;
    logic        wr_reg;
    logic [4:0]  wr_idx;
    logic [31:0] wr_wdata;
  } req_t;

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_e;

  req_t        req_in, rq;
  state_e      state, state_nxt;
  logic [1:0]  a;
  logic [3:0]  mask;
  logic        misal;
  logic        is_store, is_load;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [29:0] word_nxt;
  logic [31:0] lsh;
  logic [31:0] ld_data;
  logic        stall;

  // Bundle the execute request into one word for the stage register.
  always_comb begin
    req_in          = '0;
    req_in.mem_en   = bus.ex2mem_mem_en;
    req_in.load     = bus.ex2mem_load;
    req_in.store    = bus.ex2mem_store;
    req_in.wr_mem   = bus.ex2mem_wr_mem;
    req_in.addr     = bus.ex2mem_memaddr;
    req_in.wdata    = bus.ex2mem_wr_memwdata;
    req_in.op       = bus.ex2mem_mem_op;
    req_in.wr_reg   = bus.ex2mem_wr_reg;
    req_in.wr_idx   = bus.ex2mem_wr_regindex;
    req_in.wr_wdata = bus.ex2mem_wr_wdata;
  end

  // Stage register: reset wins over stall; stall holds the request so the
  // second half of a split store still sees the original address/data.
  always_ff @(posedge clk) begin
    if (!rstn)       rq <= '0;
    else if (!stall) rq <= req_in;
  end

  // Access size mask and word-crossing detection.
  always_comb begin
    a     = rq.addr[1:0];
    mask  = 4'b0000;
    misal = 1'b0;
    case (rq.op)
      OP_B, OP_BU: mask = 4'b0001;
      OP_H, OP_HU: begin mask = 4'b0011; misal = (a == 2'd3); end
      OP_W:        begin mask = 4'b1111; misal = (a != 2'd0); end
      default:     mask = 4'b0000;
    endcase
  end

  // Byte lanes and data shifted across an 8-byte window: the low half is
  // the first word, the high half spills into the next word.
  always_comb begin
    is_store = rq.mem_en & rq.store;
    is_load  = rq.mem_en & rq.load & ~rq.store;
    be_wide  = {4'b0000, mask} << a;
    wd_wide  = {32'd0, rq.wdata} << {a, 3'b000};
    word_nxt = rq.addr[31:2] + 30'd1;
  end

  // Load extract and sign/zero extension.
  always_comb begin
    lsh = bus.ram2mem_rdata >> {a, 3'b000};
    case (rq.op)
      OP_B:    ld_data = {{24{lsh[7]}}, lsh[7:0]};
      OP_BU:   ld_data = {24'd0, lsh[7:0]};
      OP_H:    ld_data = {{16{lsh[15]}}, lsh[15:0]};
      OP_HU:   ld_data = {16'd0, lsh[15:0]};
      default: ld_data = bus.ram2mem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: a split store spends exactly one extra cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_store && misal) state_nxt = SPLIT;
      SPLIT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: RAM write port, split-store redirect and stall.
  always_comb begin
    bus.mem2ram_we                 = 1'b0;
    bus.mem2ram_addr               = '0;
    bus.mem2ram_wdata              = '0;
    bus.mem2ram_be                 = '0;
    bus.store_misaligned_exxeption = 1'b0;
    bus.mem2ex_memadr              = '0;
    bus.mem2ex_mem_op              = '0;
    stall                          = 1'b0;
    if (state == SPLIT) begin
      bus.mem2ram_we    = 1'b1;
      bus.mem2ram_addr  = word_nxt;
      bus.mem2ram_be    = be_wide[7:4];
      bus.mem2ram_wdata = wd_wide[63:32];
    end else if (is_store) begin
      bus.mem2ram_we    = 1'b1;
      bus.mem2ram_addr  = rq.addr[31:2];
      bus.mem2ram_be    = be_wide[3:0];
      bus.mem2ram_wdata = wd_wide[31:0];
      if (misal) begin
        bus.store_misaligned_exxeption = 1'b1;
        bus.mem2ex_memadr              = {word_nxt, 2'b00};
        bus.mem2ex_mem_op              = rq.op;
        stall                          = 1'b1;
      end
    end
  end

  // Writeback mux: memory-write ops never write the register file,
  // misaligned loads trap instead of writing back.
  always_comb begin
    bus.mem2wb_wr_regindex  = rq.wr_idx;
    bus.mem2wb_wr_reg       = rq.wr_reg & ~(rq.mem_en & (rq.store | rq.wr_mem));
    bus.mem2wb_wr_wdata     = rq.wr_wdata;
    bus.load_misaligned_exp = 1'b0;
    bus.mem2wb_badaddr      = '0;
    if (is_load) begin
      if (misal) begin
        bus.load_misaligned_exp = 1'b1;
        bus.mem2wb_badaddr      = rq.addr;
        bus.mem2wb_wr_reg       = 1'b0;
        bus.mem2wb_wr_wdata     = '0;
      end else begin
        bus.mem2wb_wr_reg       = rq.wr_reg;
        bus.mem2wb_wr_wdata     = ld_data;
      end
    end
  end

  // Registered qualifiers for execute's conflict check.
  always_comb begin
    bus.mem_stall           = stall;
    bus.ex2mem_store_ffout  = rq.store;
    bus.ex2mem_mem_en_ffout = rq.mem_en;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rstn  input  1  reset, synchronous and active-low.
REQ-003 SHALL: ex2mem_mem_en / ex2mem_load / ex2mem_store / ex2mem_wr_mem  input  1 each  request qualifiers from execute.
REQ-004 SHALL: ex2mem_memaddr  input  32  byte address; ex2mem_wr_memwdata  input  32  store data; ex2mem_mem_op  input  3  0=B,1=H,2=W,4=BU,5=HU.
REQ-005 SHALL: ex2mem_wr_reg  input  1; ex2mem_wr_regindex  input  5; ex2mem_wr_wdata  input  32  non-load writeback value.
REQ-006 SHALL: ram2mem_rdata  input  32  data RAM word for the load address issued by execute the previous cycle.
REQ-007 SHALL: mem2ram_we  output  1; mem2ram_addr  output  30  word address; mem2ram_wdata  output  32; mem2ram_be  output  4  byte enables.
REQ-008 SHALL: store_misaligned_exxeption  output  1; mem2ex_memadr  output  32; mem2ex_mem_op  output  3  second-half store redirect to execute.
REQ-009 SHALL: ex2mem_store_ffout, ex2mem_mem_en_ffout  output  1 each  registered qualifiers for execute's store/load conflict check.
REQ-010 SHALL: mem_stall  output  1  hold upstream pipeline.
REQ-011 SHALL: mem2wb_wr_reg  output  1; mem2wb_wr_regindex  output  5; mem2wb_wr_wdata  output  32; load_misaligned_exp  output  1; mem2wb_badaddr  output  32.

Function
REQ-012 SHALL: capture all ex2mem_* inputs into stage registers (_ff) on each edge when mem_stall=0; hold them when mem_stall=1.
REQ-013 SHALL: 1-cycle latency: request presented in cycle N acts (RAM write, writeback outputs) in cycle N+1 from _ff values.
REQ-014 SHALL: misaligned = access crosses word boundary: H/HU with addr[1:0]=3, W with addr[1:0]!=0; B never misaligned.
REQ-015 SHALL: aligned store (mem_en_ff & store_ff): mem2ram_we=1, addr=addr_ff[31:2], be: B=0001<<a, H=0011<<a, W=1111; wdata=wdata_ff<<(8*a), a=addr_ff[1:0].
REQ-016 SHALL: FSM states IDLE, SPLIT; IDLE->SPLIT on misaligned store in IDLE; SPLIT->IDLE unconditionally next cycle.
REQ-017 SHALL: misaligned store in IDLE: write first word: be=(full mask<<a)[3:0], wdata=wdata_ff<<(8a); assert store_misaligned_exxeption=1, mem_stall=1, mem2ex_memadr={addr_ff[31:2]+1,00}, mem2ex_mem_op=op_ff.
REQ-018 SHALL: in SPLIT: write word addr_ff[31:2]+1 (30-bit wrap), be=full mask>>(4-a), wdata=wdata_ff>>(32-8a); exception and stall deasserted; ex2mem inputs ignored this cycle.
REQ-019 SHALL: store_misaligned_exxeption, mem_stall high exactly one cycle per misaligned store; mem2ex_memadr/mem2ex_mem_op=0 when not asserted.
REQ-020 SHALL: aligned load: extract byte/half at a from ram2mem_rdata; B/H sign-extend, BU/HU zero-extend, W pass; drive mem2wb_wr_wdata, mem2wb_wr_reg=wr_reg_ff.
REQ-021 SHALL: misaligned load: load_misaligned_exp=1, mem2wb_badaddr=addr_ff, mem2wb_wr_reg=0, no RAM write; otherwise both 0.
REQ-022 SHALL: non-memory op: mem2wb_wr_wdata=wr_wdata_ff, mem2wb_wr_reg=wr_reg_ff; mem2ram_we=0, be=0.
REQ-023 SHALL: mem2wb_wr_regindex=wr_regindex_ff always; stores force mem2wb_wr_reg=0.
REQ-024 SHALL: mem2ram_we=0 whenever mem_en_ff=0 or store_ff=0.

Reset
REQ-025 SHALL: rstn=0 at an edge clears all _ff registers, FSM->IDLE; thus all outputs 0 next cycle.
REQ-026 SHALL: reset in SPLIT aborts second write; no write issued after the reset edge.
REQ-027 SHALL: reset dominates stall; registers cleared even when mem_stall=1.

Verification
REQ-028 SHALL: SW addr 0x100 data 0xAABBCCDD -> next cycle we=1, addr=0x40, be=1111, wdata=0xAABBCCDD, no stall.
REQ-029 SHALL: SW addr 0x101 data 0x11223344 -> cycle1 addr=0x40, be=1110, wdata=0x22334400, exc=1, mem2ex_memadr=0x104; cycle2 addr=0x41, be=0001, wdata=0x00000011, exc=0.
REQ-030 SHALL: LB addr 0x203, rdata=0x80FFFFFF -> mem2wb_wr_wdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-031 SHALL: LHU addr 0x303 -> load_misaligned_exp=1, mem2wb_badaddr=0x303, mem2wb_wr_reg=0, we=0.
REQ-032 SHALL: SH addr 0xFFFFFFFF -> cycle1 addr=0x3FFFFFFF be=1000; cycle2 addr=0x00000000 be=0001 (wrap).
REQ-033 SHALL: rstn=0 during SPLIT of REQ-029 -> no second write, all outputs 0, FSM IDLE.
